pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed per-stage pipeline latches (F/D, D/EX, EX/M, M/WB).
- Carries one packed payload bus of arbitrary width between stages with a valid/ready handshake, an optional 2-entry skid buffer, and flush (squash).
- Invalid slots present a configurable NOP payload, so downstream decode sees a bubble instead of stale bits.
- Replaces ad-hoc global `en` stalling with local back-pressure.

Parameters:
- WIDTH, 16: payload width in bits (>=1).
- NOP_VALUE, 16'h0800 zero-extended/truncated to WIDTH: value driven on out_data whenever out_valid=0.
- SKID, 1:
  - 1 = two-entry skid buffer, in_ready registered (no comb path out_ready->in_ready).
  - 0 = single entry, in_ready combinational.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head this cycle.
- out_data  output  WIDTH  head payload, or NOP_VALUE when out_valid=0.
- flush  input  1  squash all held and incoming beats.
- occupancy  output  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Handshake:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Pop occurs when out_valid & out_ready at a rising edge.
  - Order is strict FIFO; no beat is duplicated or lost except by flush.
- State (SKID=1):
  - EMPTY (occ 0), ONE (occ 1, head only), TWO (occ 2, head+skid).
  - EMPTY: accept -> ONE.
  - ONE: accept&~pop -> TWO; pop&~accept -> EMPTY; accept&pop -> ONE, head<=in_data.
  - TWO: pop -> ONE, head<=skid. No accept is possible because in_ready=0.
- in_ready (SKID=1) = (state!=TWO) & ~rst. It is a function of registered state only.
- SKID=0:
  - Single head register.
  - in_ready = (~out_valid | out_ready) & ~rst.
  - Accept loads head and sets valid. Pop without accept clears valid.
- out_data = head when out_valid, else NOP_VALUE. It is a combinational mux on registered state.
- Stall: out_valid=1 & out_ready=0 holds out_data bit-stable for every stalled cycle.
- Flush:
  - At the next edge state -> EMPTY, occupancy -> 0, out_valid -> 0.
  - Any beat handshaken in the flush cycle is discarded. in_ready still follows its normal rule.
  - A pop in the flush cycle completes normally; downstream owns the beat.
  - Flush dominates accept, pop and skid transfer.
- Reset:
  - On any edge with rst=1: state EMPTY, out_valid=0, out_data=NOP_VALUE, occupancy=0.
  - in_ready=0 while rst high, and 1 in the first cycle after rst falls.
  - Reset mid-stall discards held entries; reset dominates flush.
- Payload registers (head/skid) need no reset; only valid/state bits are reset. They load only on accept or skid transfer to save power.
- Latency: 1 cycle from accept to out_valid when empty. Throughput is 1 beat/cycle under continuous out_ready.
- No X may propagate to out_data when out_valid=0.

Decomposition:
- Shared package pipe_pkg:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - ISA_NOP=16'h0800, the default for NOP_VALUE.
- Sub-module: existing register primitive (size param, en, rst) instantiated for head payload, skid payload (SKID=1 only, via generate) and the state register.
- Next-state logic lives in this module.

Test Plan:
- Reset then idle, WIDTH=16: out_valid=0, out_data=16'h0800, occupancy=0, in_ready=1 one cycle after rst falls.
- Stream 16'h1111, 16'h2222, 16'h3333 with out_ready=1 -> each appears one cycle after accept, in order, occupancy stays 1.
- SKID=1, head=16'hAAAA, out_ready=0, push 16'hBBBB -> occupancy=2, in_ready=0, out_data held at 16'hAAAA; raise out_ready -> 16'hAAAA then 16'hBBBB.
- Occupancy 2, assert flush with in_valid=1 carrying 16'hCCCC -> next cycle occupancy=0, out_valid=0, out_data=16'h0800, 16'hCCCC never emitted.
- Assert rst mid-stall (occupancy 2) -> next cycle empty, in_ready=0 during rst, then resume and accept 16'h4444 normally.
- SKID=0, out_valid=1, out_ready=1, in_valid=1 with 16'h5555 in same cycle -> in_ready=1 combinationally, 16'h5555 is head next cycle, no bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy/state encoding
// and the architectural NOP used to fill bubbles.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [15:0] ISA_NOP = 16'h0800;

    // State values equal the number of held entries, so the state register
    // doubles as the occupancy count.
    typedef enum logic [1:0] {
        STATE_EMPTY = ST_EMPTY,
        STATE_ONE   = ST_ONE,
        STATE_TWO   = ST_TWO
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Generic enable register with synchronous active-high reset. Payload users
// tie rst low so that only valid/state bits carry a reset.
module pipe_stage_skid_reg #(
    parameter int              SIZE    = 1,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    // Load d when enabled; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake, optional two-entry skid
// buffer (registered in_ready), flush, and NOP fill on empty slots.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(ISA_NOP),
    parameter int               SKID      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    logic [1:0]       state_raw_q;
    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] skid_q;
    logic             head_en_s;
    logic             skid_en_s;
    logic             accept_s;
    logic             pop_s;

    assign state_q   = pipe_state_e'(state_raw_q);
    assign out_valid = (state_q != STATE_EMPTY);
    assign occupancy = state_raw_q;
    assign accept_s  = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Bubbles present the NOP so unreset payload bits never leak downstream.
    assign out_data  = out_valid ? head_q : NOP_VALUE;

    // Skid mode derives ready from registered state only; single-entry mode
    // lets a pop free the slot in the same cycle.
    always_comb begin
        if (SKID != 0) begin
            in_ready = (state_q != STATE_TWO) & ~rst;
        end else begin
            in_ready = (~out_valid | out_ready) & ~rst;
        end
    end

    // Next-state and payload-load decisions; flush squashes everything held
    // and anything accepted this cycle, suppressing payload loads as well.
    always_comb begin
        state_d   = state_q;
        head_d    = (state_q == STATE_TWO) ? skid_q : in_data;
        head_en_s = 1'b0;
        skid_en_s = 1'b0;
        if (flush) begin
            state_d = STATE_EMPTY;
        end else begin
            case (state_q)
                STATE_EMPTY: begin
                    if (accept_s) begin
                        state_d   = STATE_ONE;
                        head_en_s = 1'b1;
                    end else begin
                        state_d   = STATE_EMPTY;
                    end
                end
                STATE_ONE: begin
                    if (accept_s && pop_s) begin
                        state_d   = STATE_ONE;
                        head_en_s = 1'b1;
                    end else if (accept_s) begin
                        if (SKID != 0) begin
                            state_d   = STATE_TWO;
                            skid_en_s = 1'b1;
                        end else begin
                            state_d   = STATE_ONE;
                            head_en_s = 1'b1;
                        end
                    end else if (pop_s) begin
                        state_d   = STATE_EMPTY;
                    end else begin
                        state_d   = STATE_ONE;
                    end
                end
                STATE_TWO: begin
                    if (pop_s) begin
                        state_d   = STATE_ONE;
                        head_en_s = 1'b1;
                    end else begin
                        state_d   = STATE_TWO;
                    end
                end
                default: begin
                    state_d = STATE_EMPTY;
                end
            endcase
        end
    end

    pipe_stage_skid_reg #(
        .SIZE    (2),
        .RST_VAL (ST_EMPTY)
    ) u_state_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_d),
        .q   (state_raw_q)
    );

    pipe_stage_skid_reg #(
        .SIZE (WIDTH)
    ) u_head_reg (
        .clk (clk),
        .rst (1'b0),
        .en  (head_en_s),
        .d   (head_d),
        .q   (head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_skid_reg #(
                .SIZE (WIDTH)
            ) u_skid_reg (
                .clk (clk),
                .rst (1'b0),
                .en  (skid_en_s),
                .d   (in_data),
                .q   (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = {WIDTH{1'b0}};
        end
    endgenerate

endmodule
